// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline stages: data widths, the bubble
// instruction, fetch state encoding and the IF/ID bundle layout.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  // addi x0,x0,0 : the canonical no-op placed in a pipeline bubble
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // IF/ID bundle field widths, shared with the decode stage
  localparam int IFID_PC_W   = XLEN;
  localparam int IFID_INST_W = INST_W;
  localparam int IFID_W      = 2 * IFID_PC_W + IFID_INST_W + 1;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [IFID_PC_W-1:0]   pc;
    logic [IFID_PC_W-1:0]   pc4;
    logic [IFID_INST_W-1:0] inst;
    logic                   valid;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register. Priority is reset > bubble > load > hold.
// The payload width and the bubble pattern are parameters, so the same
// block serves every inter-stage register in the pipeline.
module ifid_reg #(
  parameter int          W      = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register the payload, replacing it with the bubble pattern on reset or flush
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the instruction memory, fills the IF/ID
// register, and traps misaligned or out-of-range fetch addresses into a
// sticky fault state that only reset clears.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_data_i,
  output logic [31:0]        ifid_pc_o,
  output logic [31:0]        ifid_pc4_o,
  output logic [31:0]        ifid_inst_o,
  output logic               ifid_valid_o,
  output logic [31:0]        pc_o,
  output logic               fault_o,
  output logic [CNT_W-1:0]   fetch_count_o
);

  localparam ifid_t IFID_BUBBLE = '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};

  fetch_state_t      state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;
  logic [CNT_W-1:0]  count;
  logic              fault_now;
  logic              ifid_load;
  logic              ifid_bubble;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  assign pc_plus4  = pc + 32'd4;
  assign fault_now = (pc[1:0] != 2'b00) || (pc[XLEN-1:IMEM_AW+2] != '0);

  // Decide what the IF/ID register does this cycle: flush on redirect or a
  // faulting fetch, freeze on stall, otherwise capture the fetched word
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (state == FS_RUN) begin
      if (redirect_i) begin
        ifid_bubble = 1'b1;
      end else if (stall_i) begin
        ifid_load = 1'b0;
      end else if (fault_now) begin
        ifid_bubble = 1'b1;
      end else begin
        ifid_load = 1'b1;
      end
    end else begin
      ifid_bubble = 1'b1;
    end
  end

  assign ifid_d = '{pc: pc, pc4: pc_plus4, inst: imem_data_i, valid: 1'b1};

  ifid_reg #(
    .W      (IFID_W),
    .BUBBLE (IFID_BUBBLE)
  ) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  // PC update, fault FSM and saturating fetch counter; a fault is sticky
  // until reset, so nothing moves once FS_FAULT is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FS_RUN;
      pc      <= RESET_PC;
      fault_o <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        FS_RUN: begin
          if (redirect_i) begin
            pc <= redirect_pc_i;
          end else if (stall_i) begin
            pc <= pc;
          end else if (fault_now) begin
            state   <= FS_FAULT;
            fault_o <= 1'b1;
          end else begin
            pc <= pc_plus4;
            if (count != {CNT_W{1'b1}}) begin
              count <= count + CNT_W'(1);
            end
          end
        end
        FS_FAULT: begin
          fault_o <= 1'b1;
        end
        default: begin
          state <= FS_FAULT;
        end
      endcase
    end
  end

  // The memory address is a plain truncation; the fault check covers aliasing
  assign imem_addr_o   = pc[IMEM_AW+1:2];
  assign pc_o          = pc;
  assign fetch_count_o = count;
  assign ifid_pc_o     = ifid_q.pc;
  assign ifid_pc4_o    = ifid_q.pc4;
  assign ifid_inst_o   = ifid_q.inst;
  assign ifid_valid_o  = ifid_q.valid;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RISC-V pipeline.
- Owns the PC register and drives the word address into the asynchronous-read instruction memory.
- Latches the returned instruction into the IF/ID pipeline register with valid/bubble tracking.
- Handles hazard stalls, branch/jump redirects from EX, and fault detection for misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 6, instruction-memory word-address width; fetchable range is byte addresses 0 .. 4*2^IMEM_AW-1.
- NOP_INST, 32'h0000_0013, instruction written into IF/ID for a bubble (addi x0,x0,0).
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard unit: hold PC and IF/ID this cycle.
- redirect_i  in  1  EX: branch taken / jal / jalr; load redirect_pc_i.
- redirect_pc_i  in  32  redirect target byte address.
- imem_addr_o  out  IMEM_AW  word address to instruction memory, equal to pc[IMEM_AW+1:2], combinational from PC register.
- imem_data_i  in  32  instruction word from instruction memory, same cycle.
- ifid_pc_o  out  32  PC of instruction in IF/ID.
- ifid_pc4_o  out  32  that PC + 4, used for link address.
- ifid_inst_o  out  32  instruction in IF/ID.
- ifid_valid_o  out  1  1 = real instruction, 0 = bubble.
- pc_o  out  32  current fetch PC, for debug.
- fault_o  out  1  sticky fetch fault.
- fetch_count_o  out  CNT_W  number of valid instructions latched into IF/ID, saturating.

Behaviour:
- Reset (rst=1 at edge) overrides everything:
  - pc=RESET_PC, ifid_inst=NOP_INST, ifid_valid=0, ifid_pc=0, ifid_pc4=0.
  - fault_o=0, fetch_count=0, state=RUN.
- Two states:
  - RUN: normal fetch.
  - FAULT: sticky; exits only on rst.
- In RUN, priority per edge is redirect > stall > advance.
  - Redirect (redirect_i=1, irrespective of stall_i):
    - pc <= redirect_pc_i.
    - IF/ID <= bubble (NOP_INST, valid 0, pc fields 0).
    - Counter unchanged.
  - Stall (stall_i=1, redirect_i=0):
    - pc and all IF/ID fields hold.
    - Counter unchanged.
  - Advance (both 0):
    - IF/ID <= {pc, pc+4, imem_data_i, valid 1}.
    - pc <= pc+4, 32-bit wrap.
    - Counter += 1, saturating at all-ones.
- Fault check is combinational on the current pc; a fault exists if pc[1:0]!=0 or pc[31:IMEM_AW+2]!=0.
  - If a fault exists in RUN and neither redirect nor stall applies: no IF/ID load, IF/ID <= bubble, state -> FAULT, fault_o=1 from the next cycle.
  - A redirect in the same cycle takes precedence; the faulting PC is discarded.
  - A stall holds as normal, and the fault is re-evaluated next cycle.
- In FAULT:
  - pc holds the faulting value.
  - IF/ID holds bubble; redirect_i and stall_i are ignored.
  - fault_o=1 and the counter is frozen.
- Latency: the instruction at pc appears on ifid_inst_o one cycle after the advance edge. A redirect costs one bubble in IF/ID (EX flushes ID itself).
- Outputs imem_addr_o and pc_o are valid in every state, including immediately after reset. Truncation to IMEM_AW bits is intentional; the fault check guards aliasing.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INST constant.
  - Fetch state encoding (FS_RUN, FS_FAULT).
  - XLEN=32.
  - IF/ID bundle field widths, reused by the decode stage.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with load/hold/bubble controls and reset. Also reused by later pipeline registers with different payloads.
- PC next-logic and FSM stay in fetch_stage.

Test Plan:
- Reset then 3 free-running cycles with imem returning mem[0..2] = 0x000010B7, 0x00001117, 0x010001EF:
  - ifid_inst sequence NOP(valid 0), 0x000010B7, 0x00001117, 0x010001EF.
  - ifid_pc 0, 0, 4, 8.
  - imem_addr 0,1,2,3.
  - fetch_count 3.
- stall_i=1 for 2 cycles at pc=8: pc stays 8, IF/ID holds (pc 4, inst 0x00001117), count unchanged; on release pc=12.
- redirect_i=1 with target 0x14 while stall_i=1: next cycle pc=0x14, imem_addr=5, ifid_valid=0, ifid_inst=0x00000013.
- Redirect to 0x102 (misaligned): next cycle pc=0x102, then fault_o=1. Afterwards pc held, ifid_valid=0 for 5 further cycles despite a redirect_i pulse to 0x0; rst restores pc=0, fault_o=0.
- Run sequentially to pc=0xFC then advance: pc=0x100 is out of range for IMEM_AW=6, fault_o=1 next cycle, and the last valid IF/ID entry has pc 0xFC. Redirect arriving in the same cycle as pc=0x100 to 0x0: no fault, pc=0.
- Assert rst mid-advance with redirect_i=1: the next cycle shows reset values on every output, and the redirect is ignored.
